// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: header layout, commands, FSM states.
package prog_loader_pkg;

  localparam logic [1:0] CMD_IMEM  = 2'b00;
  localparam logic [1:0] CMD_DMEM  = 2'b01;
  localparam logic [1:0] CMD_NOP   = 2'b10;
  localparam logic [1:0] CMD_START = 2'b11;

  localparam int HDR_CMD_MSB  = 31;
  localparam int HDR_CMD_LSB  = 30;
  localparam int HDR_CNT_MSB  = 29;
  localparam int HDR_CNT_LSB  = 16;
  localparam int HDR_BASE_MSB = 15;
  localparam int HDR_BASE_LSB = 0;

  localparam int CNT_W  = HDR_CNT_MSB - HDR_CNT_LSB + 1;
  localparam int BASE_W = HDR_BASE_MSB - HDR_BASE_LSB + 1;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    DATA = 2'd1,
    CHK  = 2'd2,
    RUN  = 2'd3
  } state_t;

endpackage

// File: rtl/loader_wr_port.sv
// One memory write port of the loader: address counter, range check, registered one-cycle strobe.
module loader_wr_port
  import prog_loader_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [BASE_W-1:0] i_base,
  input  logic              i_wr,
  input  logic [31:0]       i_data,
  output logic              o_we,
  output logic [AW-1:0]     o_addr,
  output logic [31:0]       o_wdata,
  output logic              o_range_err
);

  // One bit wider than the base so base+offset never wraps back into range.
  logic [BASE_W:0] r_ptr;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic            w_in_range;

  assign w_in_range = (r_ptr < ((BASE_W+1)'(1) << AW));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= i_wr && w_in_range;
      if (i_load) begin
        r_ptr <= {1'b0, i_base};
      end else if (i_wr) begin
        r_ptr <= r_ptr + 1'b1;
        if (w_in_range) begin
          r_addr  <= r_ptr[AW-1:0];
          r_wdata <= i_data;
        end
      end
    end
  end

  assign o_we        = r_we;
  assign o_addr      = r_addr;
  assign o_wdata     = r_wdata;
  assign o_range_err = i_wr && !w_in_range;

endmodule

// File: rtl/prog_loader.sv
// Boot-time loader: parses a header/payload word stream into IMEM/DMEM writes, holds the CPU in reset until START.
// Define LOADER_CHECKSUM_EN to require a per-block checksum word and block START after any error.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  output logic               cpu_reset,
  output logic               busy,
  output logic               err,
  output logic [1:0]         o_dbg_state
);

  // Handshake: a word moves on a rising edge where in_valid && in_ready; no backpressure beyond RUN.
  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_rem;
  logic              r_tgt_dmem;
  logic              r_err;
  logic              w_acc, w_ready, w_load, w_wr, w_start_ok, w_err_set;
  logic              w_ierr, w_derr;
  logic [1:0]        w_cmd;
  logic [CNT_W-1:0]  w_cnt;
  logic [BASE_W-1:0] w_base;

  assign w_cmd  = in_data[HDR_CMD_MSB:HDR_CMD_LSB];
  assign w_cnt  = in_data[HDR_CNT_MSB:HDR_CNT_LSB];
  assign w_base = in_data[HDR_BASE_MSB:HDR_BASE_LSB];
  assign w_acc  = in_valid && !reset;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_sum;
  logic        w_chk;
  assign w_start_ok = !r_err;
  assign w_err_set  = w_ierr || w_derr || (w_chk && (in_data != r_sum));
`else
  assign w_start_ok = 1'b1;
  assign w_err_set  = w_ierr || w_derr;
`endif

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_load  = 1'b0;
    w_wr    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    w_chk   = 1'b0;
`endif
    case (r_state)
      HDR: begin
        w_ready = 1'b1;
        if (w_acc) begin
          if ((w_cmd == CMD_IMEM || w_cmd == CMD_DMEM) && w_cnt != '0) begin
            w_load = 1'b1;
            w_next = DATA;
          end else if (w_cmd == CMD_START && w_start_ok) begin
            w_next = RUN;
          end
        end
      end
      DATA: begin
        w_ready = 1'b1;
        if (w_acc) begin
          w_wr = 1'b1;
          if (r_rem == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
            w_next = CHK;
`else
            w_next = HDR;
`endif
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        w_ready = 1'b1;
        if (w_acc) begin
          w_chk  = 1'b1;
          w_next = HDR;
        end
      end
`endif
      RUN:     w_ready = 1'b0;
      default: w_next  = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= HDR;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem      <= '0;
      r_tgt_dmem <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_load) begin
        r_rem      <= w_cnt;
        r_tgt_dmem <= (w_cmd == CMD_DMEM);
      end else if (w_wr) begin
        r_rem <= r_rem - 1'b1;
      end
      r_err <= r_err || w_err_set;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)       r_sum <= '0;
    else if (w_load) r_sum <= '0;
    else if (w_wr)   r_sum <= r_sum + in_data;
  end
`endif

  loader_wr_port #(.AW(IMEM_AW)) u_imem_port (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load && w_cmd == CMD_IMEM),
    .i_base      (w_base),
    .i_wr        (w_wr && !r_tgt_dmem),
    .i_data      (in_data),
    .o_we        (imem_we),
    .o_addr      (imem_addr),
    .o_wdata     (imem_wdata),
    .o_range_err (w_ierr)
  );

  loader_wr_port #(.AW(DMEM_AW)) u_dmem_port (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load && w_cmd == CMD_DMEM),
    .i_base      (w_base),
    .i_wr        (w_wr && r_tgt_dmem),
    .i_data      (in_data),
    .o_we        (dmem_we),
    .o_addr      (dmem_addr),
    .o_wdata     (dmem_wdata),
    .o_range_err (w_derr)
  );

  assign in_ready    = w_ready && !reset;
  assign cpu_reset   = (r_state != RUN);
  assign busy        = (r_state == DATA);
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: stream-level model checked every cycle plus literal per-test expectations.
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        dmem_we;
  logic [5:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        err;
  logic [1:0]  o_dbg_state;

  prog_loader #(.IMEM_AW(8), .DMEM_AW(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .err         (err),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stream-level model: remaining payload count, write pointer, flags.
  int          m_rem, m_ptr;
  bit          m_tgt_d, m_chk, m_run, m_err, m_valid;
  logic [31:0] m_sum;
  bit          e_iwe, e_dwe, e_zero;
  logic [31:0] e_addr, e_wdata;

  // Memory images seen on the DUT write ports and write counters since last reset.
  logic [31:0] iseen [256];
  logic [31:0] dseen [64];
  int          n_iw, n_dw;

  initial begin
    m_valid = 0;
    for (int i = 0; i < 256; i++) iseen[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < 64; i++)  dseen[i] = 32'hFFFF_FFFF;
    n_iw = 0;
    n_dw = 0;
  end

  // compare process
  always @(negedge clk) begin
    if (m_valid) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, !reset && !m_run});
      chk("imem_we", {31'd0, imem_we}, {31'd0, e_iwe});
      chk("dmem_we", {31'd0, dmem_we}, {31'd0, e_dwe});
      chk("we_exclusive", {31'd0, imem_we && dmem_we}, 32'd0);
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("cpu_reset", {31'd0, cpu_reset}, {31'd0, !m_run});
      chk("busy", {31'd0, busy}, {31'd0, m_rem > 0});
      if (e_iwe) begin
        chk("imem_addr", {24'd0, imem_addr}, e_addr);
        chk("imem_wdata", imem_wdata, e_wdata);
      end
      if (e_dwe) begin
        chk("dmem_addr", {26'd0, dmem_addr}, e_addr);
        chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      if (e_zero) begin
        chk("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_dmem_addr", {26'd0, dmem_addr}, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
      end
    end
    if (imem_we === 1'b1) begin
      iseen[imem_addr] = imem_wdata;
      n_iw++;
    end
    if (dmem_we === 1'b1) begin
      dseen[dmem_addr] = dmem_wdata;
      n_dw++;
    end

    e_iwe  = 0;
    e_dwe  = 0;
    e_zero = 0;
    if (reset) begin
      m_rem = 0; m_ptr = 0; m_tgt_d = 0; m_chk = 0; m_run = 0; m_err = 0;
      m_sum = 0; m_valid = 1; e_zero = 1;
    end else if (in_valid && !m_run) begin
      if (m_rem > 0) begin
        if (m_ptr < (m_tgt_d ? 64 : 256)) begin
          e_iwe   = !m_tgt_d;
          e_dwe   = m_tgt_d;
          e_addr  = m_ptr;
          e_wdata = in_data;
        end else begin
          m_err = 1;
        end
        m_ptr++;
        m_sum += in_data;
        m_rem--;
`ifdef LOADER_CHECKSUM_EN
        if (m_rem == 0) m_chk = 1;
`endif
      end else if (m_chk) begin
        if (in_data != m_sum) m_err = 1;
        m_chk = 0;
      end else begin
        case (in_data[31:30])
          2'b00, 2'b01: begin
            if (in_data[29:16] != 0) begin
              m_rem   = in_data[29:16];
              m_ptr   = in_data[15:0];
              m_tgt_d = in_data[30];
              m_sum   = 0;
            end
          end
          2'b11: begin
`ifdef LOADER_CHECKSUM_EN
            if (!m_err) m_run = 1;
`else
            m_run = 1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // driver tasks
  logic [31:0] b_sum;

  task automatic send(input logic [31:0] w);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
    end
    in_valid = 1'b0;
    chk("send_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic send_pl(input logic [31:0] w);
    send(w);
    b_sum = b_sum + w;
  endtask

  task automatic blk_end();
`ifdef LOADER_CHECKSUM_EN
    send(b_sum);
`endif
    b_sum = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_iw  = 0;
    n_dw  = 0;
    b_sum = 0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    b_sum    = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_iw  = 0;
    n_dw  = 0;

    // T1: IMEM block of three, then START
    send(32'h0003_0000);
    send_pl(32'h0050_0093);
    send_pl(32'h00A0_0113);
    idle(2);
    send_pl(32'h0020_81B3);
    blk_end();
    settle();
    chk("t1_imem0", iseen[0], 32'h0050_0093);
    chk("t1_imem1", iseen[1], 32'h00A0_0113);
    chk("t1_imem2", iseen[2], 32'h0020_81B3);
    chk("t1_nwrites", n_iw, 32'd3);
    send(32'hC000_0000);
    settle();
    chk("t1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd0);
    do_reset();

    // T2: DMEM block at 16
    send(32'h4002_0010);
    send_pl(32'hDEAD_BEEF);
    send_pl(32'h1234_5678);
    blk_end();
    settle();
    chk("t2_dmem16", dseen[16], 32'hDEAD_BEEF);
    chk("t2_dmem17", dseen[17], 32'h1234_5678);
    chk("t2_imem_writes", n_iw, 32'd0);
    chk("t2_dmem_writes", n_dw, 32'd2);

    // T3: DMEM block crossing the top of memory, then NOP and START with err set
    send(32'h4002_003F);
    send_pl(32'hA5A5_0001);
    send_pl(32'hA5A5_0002);
    blk_end();
    settle();
    chk("t3_dmem63", dseen[63], 32'hA5A5_0001);
    chk("t3_err", {31'd0, err}, 32'd1);
    chk("t3_dmem_writes", n_dw, 32'd3);
    send(32'h8000_0000);
    send(32'hC000_0000);
    settle();
`ifdef LOADER_CHECKSUM_EN
    chk("t3_start_blocked", {31'd0, cpu_reset}, 32'd1);
`else
    chk("t3_start_with_err", {31'd0, cpu_reset}, 32'd0);
`endif
    do_reset();
    chk("t3_err_cleared", {31'd0, err}, 32'd0);

    // T4: zero-count header, then START
    send(32'h0000_0005);
    send(32'hC000_0000);
    settle();
    chk("t4_no_writes", n_iw + n_dw, 32'd0);
    chk("t4_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    do_reset();

    // T5: reset after the first of three payload words
    send(32'h0003_0000);
    send_pl(32'h1111_1111);
    settle();
    do_reset();
    chk("t5_state_hdr", {30'd0, o_dbg_state}, 32'd0);
    chk("t5_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("t5_err", {31'd0, err}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_kept_write", iseen[0], 32'h1111_1111);
    send(32'h4001_0001);
    send_pl(32'h0000_0055);
    blk_end();
    settle();
    chk("t5_hdr_after_reset", dseen[1], 32'h0000_0055);
    chk("t5_dmem_writes", n_dw, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // T6: bad checksum blocks START, good checksum releases it
    do_reset();
    send(32'h4002_0000);
    send(32'h0000_0001);
    send(32'h0000_0002);
    send(32'h0000_0004);
    settle();
    chk("t6_err_bad_sum", {31'd0, err}, 32'd1);
    send(32'hC000_0000);
    settle();
    chk("t6_start_ignored", {31'd0, cpu_reset}, 32'd1);
    chk("t6_still_ready", {31'd0, in_ready}, 32'd1);
    do_reset();
    send(32'h4002_0000);
    send(32'h0000_0001);
    send(32'h0000_0002);
    send(32'h0000_0003);
    send(32'hC000_0000);
    settle();
    chk("t6_good_sum_err", {31'd0, err}, 32'd0);
    chk("t6_start_taken", {31'd0, cpu_reset}, 32'd0);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
